// File: rtl/rc_control_voltage.sv
// RC capacitor model for the 555 VCO control voltage: once per audio sample, v_control
// moves a fixed fraction of the remaining distance toward V_HIGH (charge) or V_LOW (discharge).
module rc_control_voltage #(
    parameter int CLOCK_RATE   = 50000000,
    parameter int SAMPLE_RATE  = 48000,
    parameter int R_CHARGE     = 47000,
    parameter int R_DISCHARGE  = 27000,
    parameter int C_35_SHIFTED = 1134,
    parameter int V_HIGH       = 16384,
    parameter int V_LOW        = 0
) (
    input  logic               clk,
    input  logic               I_RST,
    input  logic               audio_clk_en,
    input  logic               charge,
    output logic signed [15:0] v_control,
    output logic               settled,
    output logic               busy
);

    // Per-sample fraction 1/(fs*R*C) in Q16; C carries a 2^35 scale, hence 2^51 on top.
    localparam longint K_CHG_RAW = (longint'(1) <<< 51) /
        (longint'(SAMPLE_RATE) * longint'(R_CHARGE) * longint'(C_35_SHIFTED));
    localparam longint K_DIS_RAW = (longint'(1) <<< 51) /
        (longint'(SAMPLE_RATE) * longint'(R_DISCHARGE) * longint'(C_35_SHIFTED));

    localparam logic [15:0] K_CHG = (K_CHG_RAW > 64'sd65535) ? 16'hFFFF : 16'(K_CHG_RAW);
    localparam logic [15:0] K_DIS = (K_DIS_RAW > 64'sd65535) ? 16'hFFFF : 16'(K_DIS_RAW);

    localparam logic signed [15:0] P_VHIGH = 16'(V_HIGH);
    localparam logic signed [15:0] P_VLOW  = 16'(V_LOW);

    // Four clocks per update is the pipeline depth, so the strobe must be at least that sparse.
    if (CLOCK_RATE < 4 * SAMPLE_RATE || V_HIGH < 1 || V_HIGH > 32767 ||
        V_LOW >= V_HIGH || V_LOW < -32768) begin : g_bad_params
        $error("rc_control_voltage: illegal parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIFF = 2'd1,
        S_MUL  = 2'd2,
        S_ACC  = 2'd3
    } state_t;

    state_t             r_state;
    logic signed [15:0] r_v;
    logic signed [15:0] r_target;
    logic        [15:0] r_k;
    logic signed [16:0] r_diff;
    logic signed [33:0] r_prod;
    logic               r_settled;
    logic               r_busy;

    logic signed [17:0] w_shift;
    logic signed [17:0] w_step;
    logic signed [15:0] w_v_next;

    // Floor of prod/2^16; K < 2^16 keeps |step| <= |diff|, so the sum never leaves the rails.
    assign w_shift = 18'(r_prod >>> 16);

    // A residual too small to move by the fractional rule still creeps one LSB per sample.
    always_comb begin
        w_step = w_shift;
        if (w_shift == '0 && r_diff != '0) begin
            w_step = r_diff[16] ? -18'sd1 : 18'sd1;
        end
    end

    assign w_v_next = 16'(r_v + w_step);

    always_ff @(posedge clk) begin
        if (I_RST) begin
            r_state   <= S_IDLE;
            r_v       <= P_VLOW;
            r_target  <= P_VLOW;
            r_k       <= '0;
            r_diff    <= '0;
            r_prod    <= '0;
            r_settled <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (audio_clk_en) begin
                        r_target <= charge ? P_VHIGH : P_VLOW;
                        r_k      <= charge ? K_CHG : K_DIS;
                        r_busy   <= 1'b1;
                        r_state  <= S_DIFF;
                    end
                end
                S_DIFF: begin
                    r_diff  <= {r_target[15], r_target} - {r_v[15], r_v};
                    r_state <= S_MUL;
                end
                S_MUL: begin
                    r_prod  <= r_diff * $signed({1'b0, r_k});
                    r_state <= S_ACC;
                end
                S_ACC: begin
                    r_v       <= w_v_next;
                    r_settled <= (w_v_next == r_target);
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign v_control = r_v;
    assign settled   = r_settled;
    assign busy      = r_busy;

endmodule

// File: tb/tb_rc_control_voltage.sv
// Bench for rc_control_voltage: vector table, hand-written charge/discharge/reset sequences,
// and a randomized run checked every clock against a sample-level reference model.
module tb_rc_control_voltage;

    localparam int V_HIGH = 16384;
    localparam int V_LOW  = 0;
    localparam int K_CHG  = 880;
    localparam int K_DIS  = 1532;

    logic               clk = 1'b0;
    logic               I_RST = 1'b1;
    logic               audio_clk_en = 1'b0;
    logic               charge = 1'b0;
    logic signed [15:0] v_control;
    logic               settled;
    logic               busy;

    int n_vec = 0;
    int n_err = 0;

    rc_control_voltage dut (
        .clk          (clk),
        .I_RST        (I_RST),
        .audio_clk_en (audio_clk_en),
        .charge       (charge),
        .v_control    (v_control),
        .settled      (settled),
        .busy         (busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, got no summary, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [15:0] exp_q[$];
    int m_v      = V_LOW;
    int m_tgt    = V_LOW;
    int m_left   = 0;
    bit m_settle = 1'b1;

    function automatic int next_v(input int v, input int tgt, input int k);
        longint d;
        longint p;
        longint s;
        d = longint'(tgt) - longint'(v);
        p = d * longint'(k);
        if (p >= 0) s = p / 65536;
        else        s = -((-p + 65535) / 65536);
        if (s == 0 && d != 0) s = (d > 0) ? 1 : -1;
        return int'(longint'(v) + s);
    endfunction

    task automatic model_edge(input logic rst, input logic en, input logic chg);
        if (rst) begin
            m_v = V_LOW; m_tgt = V_LOW; m_settle = 1'b1; m_left = 0;
            exp_q.delete();
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_v      = int'($signed(exp_q.pop_front()));
                m_settle = (m_v == m_tgt);
            end
        end else if (en) begin
            m_tgt = chg ? V_HIGH : V_LOW;
            exp_q.push_back(16'(next_v(m_v, m_tgt, chg ? K_CHG : K_DIS)));
            m_left = 3;
        end
    endtask

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        logic r, e, c;
        r = I_RST; e = audio_clk_en; c = charge;
        @(posedge clk);
        model_edge(r, e, c);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic check_ge(input string name, input int act, input int lim);
        n_vec++;
        if (act < lim) begin
            n_err++;
            $display("FAIL %s: got %0d, required >= %0d", name, act, lim);
        end
    endtask

    // One strobe followed by four idle clocks: update visible on return.
    task automatic sample(input logic chg);
        audio_clk_en = 1'b1; charge = chg;
        tick();
        audio_clk_en = 1'b0;
        repeat (4) tick();
    endtask

    task automatic do_reset();
        I_RST = 1'b1; audio_clk_en = 1'b0;
        tick();
        I_RST = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic rst;
        logic en;
        logic chg;
        int   v;
        logic s;
        logic b;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int  max_v;
        int  min_v;
        bit  found;
        int  n;

        //           rst   en    chg   v    settled busy
        tbl[0]  = '{1'b1, 1'b0, 1'b0,   0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0,   0, 1'b1, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b0,   0, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 1'b0,   0, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 1'b0,   0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1,   0, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b1,   0, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b1,   0, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 220, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 220, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 220, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 220, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 437, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 437, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 437, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 437, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 437, 1'b0, 1'b1};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 426, 1'b0, 1'b0};

        for (int i = 0; i < 18; i++) begin
            I_RST = tbl[i].rst; audio_clk_en = tbl[i].en; charge = tbl[i].chg;
            tick();
            check($sformatf("tbl%0d.v_control", i), int'($signed(v_control)), tbl[i].v);
            check($sformatf("tbl%0d.settled", i), int'(settled), int'(tbl[i].s));
            check($sformatf("tbl%0d.busy", i), int'(busy), int'(tbl[i].b));
        end
        audio_clk_en = 1'b0;

        // Full charge from 0: 1% by sample 372, exact landing on V_HIGH, no overshoot.
        do_reset();
        found = 1'b0; max_v = 0; n = 0;
        for (int k = 1; k <= 1500 && !found; k++) begin
            sample(1'b1);
            n = k;
            if (k == 1) check("charge_first_step", int'($signed(v_control)), 220);
            if (k == 1) check("charge_first_settled", int'(settled), 0);
            if (k == 372) check_ge("charge_1pct_at_372", int'($signed(v_control)), 16221);
            if (int'($signed(v_control)) > max_v) max_v = int'($signed(v_control));
            if (int'($signed(v_control)) == V_HIGH) found = 1'b1;
        end
        check("charge_reached_vhigh", int'(found), 1);
        check("charge_settled", int'(settled), 1);
        check("charge_no_overshoot", max_v, V_HIGH);
        check_ge("charge_samples_needed", n, 373);

        // Discharge from V_HIGH: first step -383, then exactly 0.
        sample(1'b0);
        check("discharge_first_step", int'($signed(v_control)), 16001);
        check("discharge_first_settled", int'(settled), 0);
        found = 1'b0; min_v = V_HIGH;
        for (int k = 1; k <= 1500 && !found; k++) begin
            sample(1'b0);
            if (int'($signed(v_control)) < min_v) min_v = int'($signed(v_control));
            if (int'($signed(v_control)) == V_LOW) found = 1'b1;
        end
        check("discharge_reached_vlow", int'(found), 1);
        check("discharge_settled", int'(settled), 1);
        check("discharge_no_undershoot", min_v, V_LOW);

        // Reset while the update is in MUL.
        do_reset();
        for (int k = 0; k < 200 && int'($signed(v_control)) < 5000; k++) sample(1'b1);
        check_ge("prereset_level", int'($signed(v_control)), 5000);
        audio_clk_en = 1'b1; charge = 1'b1;
        tick();
        audio_clk_en = 1'b0;
        tick();
        check("prereset_busy", int'(busy), 1);
        I_RST = 1'b1;
        tick();
        I_RST = 1'b0;
        check("midreset_v_control", int'($signed(v_control)), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_settled", int'(settled), 1);
        repeat (3) tick();
        check("postreset_hold", int'($signed(v_control)), 0);

        // Randomized run against the model.
        do_reset();
        charge = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            I_RST        = ($urandom_range(0, 499) == 0);
            audio_clk_en = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 149) == 0) charge = ~charge;
            tick();
            check($sformatf("rand%0d.v_control", c), int'($signed(v_control)), m_v);
            check($sformatf("rand%0d.busy", c), int'(busy), int'(m_left > 0));
            check($sformatf("rand%0d.settled", c), int'(settled), int'(m_settle));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
